// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: opcodes, FSM states,
// pending-result kinds and default cycle counts.
package md_ctrl_pkg;

  // E_MDOp encodings; unlisted values behave as MD_OP_NONE.
  localparam logic [3:0] MD_OP_NONE  = 4'd0;
  localparam logic [3:0] MD_OP_MULT  = 4'd1;
  localparam logic [3:0] MD_OP_MULTU = 4'd2;
  localparam logic [3:0] MD_OP_DIV   = 4'd3;
  localparam logic [3:0] MD_OP_DIVU  = 4'd4;
  localparam logic [3:0] MD_OP_MTHI  = 4'd5;
  localparam logic [3:0] MD_OP_MTLO  = 4'd6;
  localparam logic [3:0] MD_OP_MFHI  = 4'd7;
  localparam logic [3:0] MD_OP_MFLO  = 4'd8;
  localparam logic [3:0] MD_OP_MADD  = 4'd9;
  localparam logic [3:0] MD_OP_MADDU = 4'd10;
  localparam logic [3:0] MD_OP_MSUB  = 4'd11;
  localparam logic [3:0] MD_OP_MSUBU = 4'd12;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // How the pending 64-bit value is applied to {HI,LO} at commit.
  typedef enum logic [1:0] {
    MD_PEND_SET  = 2'd0,
    MD_PEND_ADD  = 2'd1,
    MD_PEND_SUB  = 2'd2,
    MD_PEND_SKIP = 2'd3
  } md_pend_e;

  function automatic int unsigned md_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational 32x32 multiply and divide unit. Produces the 64-bit product,
// quotient (truncated toward zero), remainder (sign of dividend) and a
// divide-by-zero flag. Signedness is selected by i_signed.
module md_alu
  import md_ctrl_pkg::*;
(
  input  logic        i_signed,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_prod,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem,
  output logic        o_div_zero
);

  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_den;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;

  // Product: extend both operands to 64 bits; the low 64 bits of the product
  // are correct for both signed and unsigned interpretations.
  always_comb begin
    w_a_ext = i_signed ? {{32{i_a[31]}}, i_a} : {32'd0, i_a};
    w_b_ext = i_signed ? {{32{i_b[31]}}, i_b} : {32'd0, i_b};
    o_prod  = w_a_ext * w_b_ext;
  end

  // Divide on magnitudes, then restore signs. 0x80000000 / -1 falls out
  // naturally as 0x80000000 remainder 0.
  always_comb begin
    w_a_neg    = i_signed & i_a[31];
    w_b_neg    = i_signed & i_b[31];
    w_a_mag    = w_a_neg ? (32'd0 - i_a) : i_a;
    w_b_mag    = w_b_neg ? (32'd0 - i_b) : i_b;
    o_div_zero = (i_b == 32'd0);
    w_den      = o_div_zero ? 32'd1 : w_b_mag;
    w_q_mag    = w_a_mag / w_den;
    w_r_mag    = w_a_mag % w_den;
    o_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    o_rem      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer for the E stage. Owns HI/LO, runs mult/multu/
// div/divu over a fixed number of busy cycles, and serves mfhi/mflo.
// Optional feature macro: MD_MADD_EN enables madd/maddu/msub/msubu (ops 9-12);
// when undefined those ops are treated as no-ops.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic        E_Start,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  output logic        E_Busy,
  output logic        E_MDStall,
  output logic [31:0] E_MDOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned CNT_MAX = md_max(MULT_CYCLES, DIV_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_pend;
  md_pend_e         r_kind;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_is_madd;
  logic        w_alu_signed;
  logic        w_start;
  md_pend_e    w_kind;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_div_zero;
  logic [63:0] w_commit;

  // Opcode decode: operation class, signedness and pending-result kind.
  always_comb begin
    w_is_mul     = 1'b0;
    w_is_div     = 1'b0;
    w_is_madd    = 1'b0;
    w_alu_signed = 1'b0;
    w_kind       = MD_PEND_SET;
    unique case (E_MDOp)
      MD_OP_MULT:  begin w_is_mul = 1'b1; w_alu_signed = 1'b1; end
      MD_OP_MULTU: w_is_mul = 1'b1;
      MD_OP_DIV:   begin w_is_div = 1'b1; w_alu_signed = 1'b1; end
      MD_OP_DIVU:  w_is_div = 1'b1;
`ifdef MD_MADD_EN
      MD_OP_MADD:  begin w_is_madd = 1'b1; w_alu_signed = 1'b1; w_kind = MD_PEND_ADD; end
      MD_OP_MADDU: begin w_is_madd = 1'b1; w_kind = MD_PEND_ADD; end
      MD_OP_MSUB:  begin w_is_madd = 1'b1; w_alu_signed = 1'b1; w_kind = MD_PEND_SUB; end
      MD_OP_MSUBU: begin w_is_madd = 1'b1; w_kind = MD_PEND_SUB; end
`endif
      default: ;
    endcase
    if (w_is_div) begin
      w_kind = w_div_zero ? MD_PEND_SKIP : MD_PEND_SET;
    end
    w_start = (r_state == MD_IDLE) & E_Start & (w_is_mul | w_is_div | w_is_madd);
  end

  md_alu u_md_alu (
    .i_signed   (w_alu_signed),
    .i_a        (E_RS),
    .i_b        (E_RT),
    .o_prod     (w_prod),
    .o_quot     (w_quot),
    .o_rem      (w_rem),
    .o_div_zero (w_div_zero)
  );

  // Value written to {HI,LO} at commit; accumulation uses HI/LO at that edge.
  always_comb begin
    w_commit = r_pend;
    unique case (r_kind)
      MD_PEND_ADD: w_commit = {r_hi, r_lo} + r_pend;
      MD_PEND_SUB: w_commit = {r_hi, r_lo} - r_pend;
      default:     w_commit = r_pend;
    endcase
  end

  // Sequencer FSM: accepts a start or mthi/mtlo in IDLE, counts down in BUSY,
  // commits the pending result on the last busy cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_kind  <= MD_PEND_SET;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      unique case (r_state)
        MD_IDLE: begin
          if (w_start) begin
            r_state <= MD_BUSY;
            r_cnt   <= w_is_div ? DIV_LD : MULT_LD;
            r_pend  <= w_is_div ? {w_rem, w_quot} : w_prod;
            r_kind  <= w_kind;
          end else if (E_MDOp == MD_OP_MTHI) begin
            r_hi <= E_RS;
          end else if (E_MDOp == MD_OP_MTLO) begin
            r_lo <= E_RS;
          end
        end
        MD_BUSY: begin
          // Starts and mthi/mtlo arriving here are deliberately dropped.
          if (r_cnt == CNT_W'(1)) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            if (r_kind != MD_PEND_SKIP) begin
              {r_hi, r_lo} <= w_commit;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  // Outputs: busy/stall to the hazard unit and mfhi/mflo read path.
  always_comb begin
    E_Busy    = (r_state == MD_BUSY);
    E_MDStall = E_Busy | E_Start;
    HI        = r_hi;
    LO        = r_lo;
    unique case (E_MDOp)
      MD_OP_MFHI: E_MDOut = r_hi;
      MD_OP_MFLO: E_MDOut = r_lo;
      default:    E_MDOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl. Expected HI/LO values come from a
// reference model and are queued at issue, then popped when busy drops.
`timescale 1ns/1ps
module tb_md_ctrl;
  import md_ctrl_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  E_MDOp;
  logic        E_Start;
  logic [31:0] E_RS;
  logic [31:0] E_RT;
  logic        E_Busy;
  logic        E_MDStall;
  logic [31:0] E_MDOut;
  logic [31:0] HI;
  logic [31:0] LO;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_ctrl #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .E_MDOp    (E_MDOp),
    .E_Start   (E_Start),
    .E_RS      (E_RS),
    .E_RT      (E_RT),
    .E_Busy    (E_Busy),
    .E_MDStall (E_MDStall),
    .E_MDOut   (E_MDOut),
    .HI        (HI),
    .LO        (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Reference model: new {HI,LO} for an op given operands and current HI/LO.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'd0, a} * {32'd0, b};
    case (op)
      MD_OP_MULT:  return 64'(sa * sb);
      MD_OP_MULTU: return up;
      MD_OP_DIV: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MD_OP_DIVU: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      MD_OP_MADD:  return {hi, lo} + 64'(sa * sb);
      MD_OP_MADDU: return {hi, lo} + up;
      MD_OP_MSUB:  return {hi, lo} - 64'(sa * sb);
      MD_OP_MSUBU: return {hi, lo} - up;
      default:     return {hi, lo};
    endcase
  endfunction

  function automatic int cycles_for(input logic [3:0] op);
    return (op == MD_OP_DIV || op == MD_OP_DIVU) ? DC : MC;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    E_MDOp  = MD_OP_NONE;
    E_Start = 1'b0;
    E_RS    = 32'd0;
    E_RT    = 32'd0;
  endtask

  // Issue one sequence, count busy cycles and compare the committed result.
  task automatic run_seq(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    int n;
    logic [63:0] exp;
    sb_q.push_back(model(op, a, b, m_hi, m_lo));
    E_MDOp = op; E_Start = 1'b1; E_RS = a; E_RT = b;
    #1;
    checks++;
    if (E_MDStall !== 1'b1) $display("FAIL %s_stall: got %b want 1", name, E_MDStall);
    if (E_MDStall !== 1'b1) errors++;
    tick();
    idle_inputs();
    n = 0;
    while (E_Busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != cycles_for(op)) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d want %0d", name, n, cycles_for(op));
    end
    exp = sb_q.pop_front();
    checks++;
    if (HI !== exp[63:32]) begin
      errors++;
      $display("FAIL %s_hi: got %h want %h", name, HI, exp[63:32]);
    end
    checks++;
    if (LO !== exp[31:0]) begin
      errors++;
      $display("FAIL %s_lo: got %h want %h", name, LO, exp[31:0]);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (E_Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b hi=%h lo=%h want 0/0/0", E_Busy, HI, LO);
    end
    reset = 1'b1;
    tick();
    E_MDOp = MD_OP_MFHI;
    #1;
    checks++;
    if (E_MDOut !== 32'd0) begin
      errors++;
      $display("FAIL reset_mfhi: got %h want 0", E_MDOut);
    end
    E_MDOp = MD_OP_MFLO;
    #1;
    checks++;
    if (E_MDOut !== 32'd0 || E_MDStall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mflo: got out=%h stall=%b want 0/0", E_MDOut, E_MDStall);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_mult();
    run_seq("mult", MD_OP_MULT, 32'hFFFFFFFE, 32'd3);
    checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL mult_const: got %h_%h want ffffffff_fffffffa", HI, LO);
    end
    run_seq("multu", MD_OP_MULTU, 32'hFFFFFFFE, 32'd3);
    checks++;
    if (HI !== 32'h00000002 || LO !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL multu_const: got %h_%h want 00000002_fffffffa", HI, LO);
    end
  endtask

  task automatic test_div();
    run_seq("div", MD_OP_DIV, 32'hFFFFFFF9, 32'd2);
    checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL div_const: got %h_%h want ffffffff_fffffffd", HI, LO);
    end
    run_seq("divu_zero", MD_OP_DIVU, 32'd7, 32'd0);
    checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL divu_zero_keep: got %h_%h want ffffffff_fffffffd", HI, LO);
    end
    run_seq("div_ovf", MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    checks++;
    if (HI !== 32'd0 || LO !== 32'h80000000) begin
      errors++;
      $display("FAIL div_ovf_const: got %h_%h want 00000000_80000000", HI, LO);
    end
  endtask

  task automatic test_mthi_mtlo();
    E_MDOp = MD_OP_MTHI; E_RS = 32'h12345678;
    tick();
    E_MDOp = MD_OP_MTLO; E_RS = 32'h9ABCDEF0;
    tick();
    m_hi = 32'h12345678;
    m_lo = 32'h9ABCDEF0;
    E_MDOp = MD_OP_MFLO; E_RS = 32'd0;
    #1;
    checks++;
    if (E_MDOut !== 32'h9ABCDEF0) begin
      errors++;
      $display("FAIL mflo: got %h want 9abcdef0", E_MDOut);
    end
    E_MDOp = MD_OP_MFHI;
    #1;
    checks++;
    if (E_MDOut !== 32'h12345678) begin
      errors++;
      $display("FAIL mfhi: got %h want 12345678", E_MDOut);
    end
    E_MDOp = MD_OP_NONE;
    #1;
    checks++;
    if (E_MDOut !== 32'd0) begin
      errors++;
      $display("FAIL mdout_none: got %h want 0", E_MDOut);
    end
    tick();
  endtask

  // mtlo, mfhi and a second start injected while busy.
  task automatic test_overlap();
    int n;
    logic [63:0] exp;
    sb_q.push_back(model(MD_OP_MULT, 32'h00010000, 32'h00010000, m_hi, m_lo));
    E_MDOp = MD_OP_MULT; E_Start = 1'b1; E_RS = 32'h00010000; E_RT = 32'h00010000;
    tick();
    idle_inputs();
    n = 0;
    while (E_Busy === 1'b1 && n < 100) begin
      n++;
      case (n)
        1: begin E_MDOp = MD_OP_MTLO; E_RS = 32'hDEADBEEF; end
        2: begin
          E_MDOp = MD_OP_MFHI;
          #1;
          checks++;
          if (E_MDOut !== m_hi) begin
            errors++;
            $display("FAIL overlap_mfhi_old: got %h want %h", E_MDOut, m_hi);
          end
        end
        3: begin
          E_MDOp = MD_OP_DIV; E_Start = 1'b1; E_RS = 32'd100; E_RT = 32'd7;
          #1;
          checks++;
          if (E_MDStall !== 1'b1) begin
            errors++;
            $display("FAIL overlap_stall: got %b want 1", E_MDStall);
          end
        end
        default: ;
      endcase
      tick();
      idle_inputs();
    end
    checks++;
    if (n != MC) begin
      errors++;
      $display("FAIL overlap_busy_cycles: got %0d want %0d", n, MC);
    end
    exp = sb_q.pop_front();
    checks++;
    if ({HI, LO} !== exp) begin
      errors++;
      $display("FAIL overlap_result: got %h_%h want %h", HI, LO, exp);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    tick();
    checks++;
    if (E_Busy !== 1'b0) begin
      errors++;
      $display("FAIL overlap_no_restart: got busy=%b want 0", E_Busy);
    end
  endtask

  task automatic test_reset_mid();
    E_MDOp = MD_OP_MTLO; E_RS = 32'h00000055;
    tick();
    E_MDOp = MD_OP_DIV; E_Start = 1'b1; E_RS = 32'd1000; E_RT = 32'd3;
    tick();
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (E_Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b hi=%h lo=%h want 0/0/0", E_Busy, HI, LO);
    end
    tick();
    reset = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (DC) tick();
    checks++;
    if (E_Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_after: got busy=%b hi=%h lo=%h want 0/0/0", E_Busy, HI, LO);
    end
  endtask

`ifdef MD_MADD_EN
  task automatic test_madd();
    E_MDOp = MD_OP_MTHI; E_RS = 32'd0;
    tick();
    E_MDOp = MD_OP_MTLO; E_RS = 32'd5;
    tick();
    m_hi = 32'd0;
    m_lo = 32'd5;
    run_seq("madd", MD_OP_MADD, 32'd3, 32'd4);
    checks++;
    if (HI !== 32'd0 || LO !== 32'd17) begin
      errors++;
      $display("FAIL madd_const: got %h_%h want 00000000_00000011", HI, LO);
    end
    run_seq("msub", MD_OP_MSUB, 32'hFFFFFFFF, 32'd20);
    run_seq("maddu", MD_OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_seq("msubu", MD_OP_MSUBU, 32'h80000000, 32'd2);
  endtask
`else
  task automatic test_madd();
    E_MDOp = MD_OP_MADD; E_Start = 1'b1; E_RS = 32'd3; E_RT = 32'd4;
    tick();
    idle_inputs();
    checks++;
    if (E_Busy !== 1'b0) begin
      errors++;
      $display("FAIL madd_off_busy: got %b want 0", E_Busy);
    end
    repeat (MC) tick();
    checks++;
    if (HI !== m_hi || LO !== m_lo) begin
      errors++;
      $display("FAIL madd_off_keep: got %h_%h want %h_%h", HI, LO, m_hi, m_lo);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      b  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
      run_seq("random", op, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_overlap();
    test_reset_mid();
    test_madd();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
